// File: rtl/sigarch_stream_buffer.sv
// sigarch_stream_buffer: DEPTH-entry first-word-fall-through stream buffer, cut-through or whole-packet release.
// One cycle from write to visibility; stream_in_rdy tracks only full/rst, never stream_out_rdy.

// Generic FWFT FIFO: read data is mem[rd_ptr] combinationally, one cycle after the write.
// Caller must gate wr_en with !full and rd_en with !empty.
module sigarch_stream_buffer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is deliberately left out of reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign rd_dat = mem[rd_ptr];
  assign full   = (level == FULL_LVL);
  assign empty  = (level == '0);
endmodule

// Stream buffer top: data/keep/last stored as one beat; PKT_MODE=1 holds output until a whole
// packet is stored, or the buffer is full so packets longer than DEPTH still drain.
module sigarch_stream_buffer #(
  parameter int DATA_W   = 8,
  parameter int KEEP_W   = DATA_W / 8,
  parameter int DEPTH    = 16,
  parameter int PKT_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        stream_in_dat,
  input  logic [KEEP_W-1:0]        stream_in_keep,
  input  logic                     stream_in_last,
  input  logic                     stream_in_vld,
  output logic                     stream_in_rdy,
  output logic [DATA_W-1:0]        stream_out_dat,
  output logic [KEEP_W-1:0]        stream_out_keep,
  output logic                     stream_out_last,
  output logic                     stream_out_vld,
  input  logic                     stream_out_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic                     full,
  output logic                     empty
);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  beat_t in_beat;
  beat_t out_beat;
  logic  wr_en;
  logic  rd_en;
  logic  release_ok;

  assign in_beat.dat  = stream_in_dat;
  assign in_beat.keep = stream_in_keep;
  assign in_beat.last = stream_in_last;

  assign stream_in_rdy = !full && !rst;
  assign wr_en         = stream_in_vld && stream_in_rdy;

  // Full overrides the packet gate, otherwise an oversized packet would wedge the buffer.
  assign release_ok     = (PKT_MODE == 0) || (pkt_count != '0) || full;
  assign stream_out_vld = !empty && !rst && release_ok;
  assign rd_en          = stream_out_vld && stream_out_rdy;

  sigarch_stream_buffer_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_dat (in_beat),
    .rd_en  (rd_en),
    .rd_dat (out_beat),
    .level  (level),
    .full   (full),
    .empty  (empty)
  );

  assign stream_out_dat  = out_beat.dat;
  assign stream_out_keep = out_beat.keep;
  assign stream_out_last = out_beat.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else begin
      case ({wr_en && stream_in_last, rd_en && out_beat.last})
        2'b10:   pkt_count <= pkt_count + LW'(1);
        2'b01:   pkt_count <= pkt_count - LW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end
endmodule

// File: tb/tb_sigarch_stream_buffer.sv
// Bench for sigarch_stream_buffer: three instances (cut-through/16, packet/16, packet/4) on shared stimulus.
module tb_sigarch_stream_buffer;
  logic       clk;
  logic       rst;
  logic [7:0] in_dat;
  logic       in_keep;
  logic       in_last;
  logic       in_vld;
  logic       out_rdy;

  logic [7:0] o_dat   [3];
  logic       o_keep  [3];
  logic       o_last  [3];
  logic       o_vld   [3];
  logic       i_rdy   [3];
  logic       o_full  [3];
  logic       o_empty [3];
  logic [4:0] lvl0, lvl1, pkt0, pkt1;
  logic [2:0] lvl2, pkt2;
  int         o_lvl   [3];
  int         o_pkt   [3];

  assign o_lvl[0] = int'(lvl0);
  assign o_lvl[1] = int'(lvl1);
  assign o_lvl[2] = int'(lvl2);
  assign o_pkt[0] = int'(pkt0);
  assign o_pkt[1] = int'(pkt1);
  assign o_pkt[2] = int'(pkt2);

  sigarch_stream_buffer #(.DATA_W(8), .DEPTH(16), .PKT_MODE(0)) u_ct (
    .clk(clk), .rst(rst),
    .stream_in_dat(in_dat), .stream_in_keep(in_keep), .stream_in_last(in_last),
    .stream_in_vld(in_vld), .stream_in_rdy(i_rdy[0]),
    .stream_out_dat(o_dat[0]), .stream_out_keep(o_keep[0]), .stream_out_last(o_last[0]),
    .stream_out_vld(o_vld[0]), .stream_out_rdy(out_rdy),
    .level(lvl0), .pkt_count(pkt0), .full(o_full[0]), .empty(o_empty[0]));

  sigarch_stream_buffer #(.DATA_W(8), .DEPTH(16), .PKT_MODE(1)) u_sf (
    .clk(clk), .rst(rst),
    .stream_in_dat(in_dat), .stream_in_keep(in_keep), .stream_in_last(in_last),
    .stream_in_vld(in_vld), .stream_in_rdy(i_rdy[1]),
    .stream_out_dat(o_dat[1]), .stream_out_keep(o_keep[1]), .stream_out_last(o_last[1]),
    .stream_out_vld(o_vld[1]), .stream_out_rdy(out_rdy),
    .level(lvl1), .pkt_count(pkt1), .full(o_full[1]), .empty(o_empty[1]));

  sigarch_stream_buffer #(.DATA_W(8), .DEPTH(4), .PKT_MODE(1)) u_sf4 (
    .clk(clk), .rst(rst),
    .stream_in_dat(in_dat), .stream_in_keep(in_keep), .stream_in_last(in_last),
    .stream_in_vld(in_vld), .stream_in_rdy(i_rdy[2]),
    .stream_out_dat(o_dat[2]), .stream_out_keep(o_keep[2]), .stream_out_last(o_last[2]),
    .stream_out_vld(o_vld[2]), .stream_out_rdy(out_rdy),
    .level(lvl2), .pkt_count(pkt2), .full(o_full[2]), .empty(o_empty[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @%0t: got %0d (0x%0h) expected %0d (0x%0h)", nm, idx, $time, act, act, exp, exp);
    end
  endtask

  // Reference model: each buffer is just an ordered list of stored beats.
  typedef struct packed {
    logic [7:0] dat;
    logic       keep;
    logic       last;
  } mbeat_t;

  mbeat_t     mq [3][$];
  logic [7:0] rx4 [$];

  function automatic int dep(input int i);
    return (i == 2) ? 4 : 16;
  endfunction

  function automatic int nlast(input int i);
    int n = 0;
    for (int j = 0; j < mq[i].size(); j++) begin
      if (mq[i][j].last) n++;
    end
    return n;
  endfunction

  function automatic bit m_vld(input int i);
    bit pkt_ok;
    pkt_ok = (i == 0) || (nlast(i) > 0) || (mq[i].size() == dep(i));
    return !rst && (mq[i].size() > 0) && pkt_ok;
  endfunction

  function automatic bit m_rdy(input int i);
    return !rst && (mq[i].size() < dep(i));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit     wr, rd;
      mbeat_t b;
      if (rst) begin
        mq[i].delete();
      end else begin
        wr = in_vld && m_rdy(i);
        rd = m_vld(i) && out_rdy;
        b.dat  = in_dat;
        b.keep = in_keep;
        b.last = in_last;
        if (rd) void'(mq[i].pop_front());
        if (wr) mq[i].push_back(b);
      end
    end
    if (o_vld[2] && out_rdy) rx4.push_back(o_dat[2]);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("in_rdy",    i, int'(i_rdy[i]),   int'(m_rdy(i)));
      chk("out_vld",   i, int'(o_vld[i]),   int'(m_vld(i)));
      chk("level",     i, o_lvl[i],         mq[i].size());
      chk("pkt_count", i, o_pkt[i],         nlast(i));
      chk("full",      i, int'(o_full[i]),  int'(mq[i].size() == dep(i)));
      chk("empty",     i, int'(o_empty[i]), int'(mq[i].size() == 0));
      if (m_vld(i)) begin
        chk("out_dat",  i, int'(o_dat[i]),  int'(mq[i][0].dat));
        chk("out_keep", i, int'(o_keep[i]), int'(mq[i][0].keep));
        chk("out_last", i, int'(o_last[i]), int'(mq[i][0].last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc;
    bit acc;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
    in_dat = '0; in_keep = 1'b1; in_last = 1'b0;

    // Reset held for 3 cycles, then ready comes up as soon as rst drops
    tick();
    repeat (3) begin
      tick();
      chk("t1_rdy", 0, int'(i_rdy[0]), 0);
      chk("t1_vld", 0, int'(o_vld[0]), 0);
      chk("t1_lvl", 0, o_lvl[0], 0);
      chk("t1_empty", 0, int'(o_empty[0]), 1);
    end
    rst = 1'b0;
    #1;
    chk("t1_rdy_rel", 0, int'(i_rdy[0]), 1);
    tick();

    // Cut-through pass of three beats with the sink always ready
    do_reset(1);
    out_rdy = 1'b1; in_keep = 1'b1;
    in_vld = 1'b1; in_dat = 8'h11; in_last = 1'b0; tick();
    chk("t2_d0", 0, int'(o_dat[0]), 'h11); chk("t2_l0", 0, int'(o_last[0]), 0); chk("t2_lv0", 0, o_lvl[0], 1);
    in_dat = 8'h22; tick();
    chk("t2_d1", 0, int'(o_dat[0]), 'h22); chk("t2_l1", 0, int'(o_last[0]), 0); chk("t2_lv1", 0, o_lvl[0], 1);
    in_dat = 8'h33; in_last = 1'b1; tick();
    chk("t2_d2", 0, int'(o_dat[0]), 'h33); chk("t2_l2", 0, int'(o_last[0]), 1); chk("t2_lv2", 0, o_lvl[0], 1);
    in_vld = 1'b0; in_last = 1'b0; tick();
    chk("t2_lv3", 0, o_lvl[0], 0);

    // Fill to DEPTH, stall, then a read cycle that blocks the write
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      in_vld = 1'b1; in_dat = 8'(8'h60 + i); in_last = 1'b0; tick();
    end
    chk("t3_lvl", 0, o_lvl[0], 16); chk("t3_full", 0, int'(o_full[0]), 1); chk("t3_rdy", 0, int'(i_rdy[0]), 0);
    in_dat = 8'h77; tick();
    chk("t3_stall", 0, o_lvl[0], 16);
    out_rdy = 1'b1; #1;
    chk("t3_rdy_blk", 0, int'(i_rdy[0]), 0);
    tick();
    chk("t3_rd_lvl", 0, o_lvl[0], 15); chk("t3_rd_head", 0, int'(o_dat[0]), 'h61);
    out_rdy = 1'b0; tick();
    chk("t3_wr_lvl", 0, o_lvl[0], 16);
    in_vld = 1'b0;

    // Packet mode holds three beats through a gap until last arrives
    do_reset(1);
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; in_dat = 8'(8'h41 + i); in_last = 1'b0; tick();
    end
    in_vld = 1'b0;
    repeat (5) begin
      tick();
      chk("t4_hold", 1, int'(o_vld[1]), 0);
    end
    in_vld = 1'b1; in_dat = 8'h44; in_last = 1'b1; tick();
    in_vld = 1'b0; in_last = 1'b0;
    chk("t4_vld", 1, int'(o_vld[1]), 1); chk("t4_pkt", 1, o_pkt[1], 1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", 1, int'(o_dat[1]), 'h41 + i);
      chk("t4_dvld", 1, int'(o_vld[1]), 1);
      tick();
    end
    chk("t4_pkt_end", 1, o_pkt[1], 0); chk("t4_vld_end", 1, int'(o_vld[1]), 0);

    // Packet longer than DEPTH=4 drains through the full escape
    do_reset(1);
    rx4.delete();
    out_rdy = 1'b1; k = 0; cyc = 0;
    while (rx4.size() < 6 && cyc < 200) begin
      in_vld = (k < 6); in_dat = 8'('h51 + k); in_last = (k == 5); in_keep = 1'b1;
      @(posedge clk);
      acc = in_vld && i_rdy[2];
      #1;
      if (acc) k++;
      cyc++;
    end
    in_vld = 1'b0; in_last = 1'b0;
    chk("t5_count", 2, rx4.size(), 6);
    for (int j = 0; j < 6; j++) begin
      chk("t5_order", 2, (j < rx4.size()) ? int'(rx4[j]) : -1, 'h51 + j);
    end

    // Reset mid-packet discards stored beats; a fresh packet then passes
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; in_dat = 8'(8'h90 + i); in_last = 1'b0; tick();
    end
    in_vld = 1'b0;
    chk("t6_lvl3", 0, o_lvl[0], 3);
    rst = 1'b1; out_rdy = 1'b1; #1;
    chk("t6_rst_vld", 0, int'(o_vld[0]), 0); chk("t6_rst_rdy", 0, int'(i_rdy[0]), 0);
    tick();
    chk("t6_lvl0", 0, o_lvl[0], 0);
    rst = 1'b0; #1;
    chk("t6_rdy", 0, int'(i_rdy[0]), 1);
    in_vld = 1'b1; in_dat = 8'hA5; in_keep = 1'b1; in_last = 1'b1; tick();
    in_vld = 1'b0; in_last = 1'b0;
    chk("t6_vld", 0, int'(o_vld[0]), 1); chk("t6_dat", 0, int'(o_dat[0]), 'hA5);
    chk("t6_keep", 0, int'(o_keep[0]), 1); chk("t6_last", 0, int'(o_last[0]), 1);
    tick();
    chk("t6_done", 0, o_lvl[0], 0);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      in_vld  = ($urandom % 4) != 0;
      in_dat  = 8'($urandom);
      in_keep = 1'($urandom);
      in_last = ($urandom % 4) == 0;
      out_rdy = ($urandom % 3) != 0;
      rst     = ($urandom % 256) == 0;
      tick();
    end
    rst = 1'b0; in_vld = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
